// File: rtl/pdp8_ifd_prefetch.sv
// pdp8_ifd_prefetch: PDP-8 instruction prefetch queue with opcode pre-decode.
// Issues sequential memory reads ahead of the exec unit, buffers up to DEPTH
// words with their addresses, and handles redirects (pc_load) by flushing.
// Optional macro IFD_HLT_STOP_EN: an HLT word (7402 octal) stops fetching when
// it is queued and parks the unit in DONE once it is consumed.
module pdp8_ifd_prefetch #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(12'o200)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_value,
  output logic                  ifu_rd_req,
  output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  input  logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [5:0]            mem_op,
  output logic                  iot_op,
  output logic                  op7_op,
  output logic                  done
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic                   infl_q, infl_d;
  logic                   stop_q, stop_d;
  logic [ADDR_WIDTH-1:0]  infl_addr_q;
  logic [DATA_WIDTH-1:0]  word_q [DEPTH];
  logic [ADDR_WIDTH-1:0]  wpc_q  [DEPTH];

  logic             fetching, head_valid, pop, push, redirect, room, req;
  logic             hlt_in, hlt_pop, stop_pend;
  logic [CNT_W:0]   occ;
  logic [2:0]       opcode;

  assign fetching   = (state_q == S_FETCH);
  assign head_valid = fetching && (count_q != '0);
  assign pop        = head_valid && !stall;
  assign redirect   = fetching && pc_load;
  // A word arriving alongside a redirect belongs to the old stream and is dropped.
  assign push       = fetching && infl_q && !redirect && ((count_q != FULL) || pop);
  // Queued words plus the outstanding read must leave room for the reply.
  assign occ        = {1'b0, count_q} + {{CNT_W{1'b0}}, infl_q};
  assign room       = (occ < {1'b0, FULL});

`ifdef IFD_HLT_STOP_EN
  localparam logic [DATA_WIDTH-1:0] HLT_WORD = DATA_WIDTH'(12'o7402);
  assign hlt_in  = push && (ifu_rd_data == HLT_WORD);
  assign hlt_pop = pop && (word_q[rd_ptr_q] == HLT_WORD);
  assign done    = (state_q == S_DONE) && !reset;
`else
  assign hlt_in  = 1'b0;
  assign hlt_pop = 1'b0;
  assign done    = 1'b0;
`endif

  assign stop_pend = stop_q || hlt_in;
  assign req       = fetching && room && !pc_load && !stop_pend;

  // Outputs are forced to their idle values for as long as reset is held.
  assign ifu_rd_req  = req && !reset;
  assign ifu_rd_addr = reset ? START_ADDR : addr_q;
  assign instr_valid = head_valid && !reset;
  assign instr       = instr_valid ? word_q[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? wpc_q[rd_ptr_q] : '0;
  assign opcode      = instr[DATA_WIDTH-1 -: 3];

  // Pre-decode the head opcode; everything reads zero with no valid head.
  always_comb begin
    mem_op = '0;
    iot_op = 1'b0;
    op7_op = 1'b0;
    if (instr_valid) begin
      case (opcode)
        3'd6:    iot_op = 1'b1;
        3'd7:    op7_op = 1'b1;
        default: mem_op = 6'd1 << opcode;
      endcase
    end
  end

  // Next-state logic: FSM, fetch address, queue pointers and occupancy.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    infl_d   = req;
    stop_d   = stop_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (req)  addr_d   = addr_q + ADDR_WIDTH'(1);
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
        if (hlt_in) stop_d = 1'b1;
        // Redirect: the same-cycle pop has already advanced; drop the rest.
        if (redirect) begin
          addr_d   = pc_value;
          count_d  = '0;
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          stop_d   = 1'b0;
        end
        if (hlt_pop) begin
          state_d  = S_DONE;
          count_d  = '0;
          rd_ptr_d = '0;
          wr_ptr_d = '0;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= START_ADDR;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      infl_q   <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      infl_q   <= infl_d;
      stop_q   <= stop_d;
    end
  end

  // Queue storage: remember the outstanding address, capture returned words.
  always_ff @(posedge clk) begin
    if (req) infl_addr_q <= addr_q;
    if (push) begin
      word_q[wr_ptr_q] <= ifu_rd_data;
      wpc_q[wr_ptr_q]  <= infl_addr_q;
    end
  end

endmodule

// File: doc/pdp8_ifd_prefetch.md
PDP8_IFD_PREFETCH -- requirements
Module: pdp8_ifd_prefetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, width of the instruction address.
REQ-002 Parameter DATA_WIDTH, default 12, width of the instruction word; opcode is bits [DATA_WIDTH-1:DATA_WIDTH-3].
REQ-003 Parameter DEPTH, default 4, number of prefetch queue entries; legal values are powers of two, 2..16.
REQ-004 Parameter START_ADDR, default 12'o200, fetch address after reset.
REQ-005 Ports: one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1 bit, rising-edge clock.
REQ-007 Port reset, input, 1 bit, synchronous active-high reset.
REQ-008 Port stall, input, 1 bit, exec unit cannot accept an instruction this cycle.
REQ-009 Port pc_load, input, 1 bit, redirect request from exec.
REQ-010 Port pc_value, input, ADDR_WIDTH bits, redirect target.
REQ-011 Port ifu_rd_req, output, 1 bit, memory read strobe.
REQ-012 Port ifu_rd_addr, output, ADDR_WIDTH bits, memory read address.
REQ-013 Port ifu_rd_data, input, DATA_WIDTH bits, read data, valid exactly 1 cycle after ifu_rd_req.
REQ-014 Port instr_valid, output, 1 bit, queue head holds a valid instruction.
REQ-015 Port instr, output, DATA_WIDTH bits, queue head word.
REQ-016 Port instr_pc, output, ADDR_WIDTH bits, address of the queue head word.
REQ-017 Port mem_op, output, 6 bits, one-hot AND/TAD/ISZ/DCA/JMS/JMP (bits 0..5) for opcodes 0..5.
REQ-018 Port iot_op, output, 1 bit, opcode 6.
REQ-019 Port op7_op, output, 1 bit, opcode 7.
REQ-020 Port done, output, 1 bit, unit is in DONE.

Function
REQ-021 The FSM states are IDLE, FETCH, and DONE. Reset enters IDLE, IDLE always goes to FETCH after 1 cycle, and only reset leaves DONE.
REQ-022 In FETCH, ifu_rd_req is 1 when queue count plus in-flight reads is less than DEPTH, pc_load is 0, and no stop is pending.
REQ-023 Back-to-back requests are allowed. After each request, ifu_rd_addr increments modulo 2^ADDR_WIDTH, so 7777 octal is followed by 0000.
REQ-024 Returned data is pushed with its address the cycle it arrives. instr_valid rises the cycle after the push; fetch-to-valid latency is 2 cycles.
REQ-025 A pop occurs when instr_valid=1 and stall=0. The queue is never pushed when full and never popped when empty.
REQ-026 Simultaneous push and pop on a full queue is legal and leaves the count unchanged.
REQ-027 mem_op, iot_op and op7_op decode combinationally from instr. All three are 0 when instr_valid=0.
REQ-028 On pc_load in FETCH, the handling is as follows:
- A pop in the same cycle completes first.
- The queue is then flushed.
- Read data returning in the next cycle is discarded.
- ifu_rd_addr is set to pc_value.
- ifu_rd_req resumes the cycle after pc_load.
REQ-029 pc_load is ignored in IDLE and in DONE.
REQ-030 Under stall=1, fetching continues until the queue fills, then ifu_rd_req holds 0 until the next pop.

Reset
REQ-031 While reset=1, all outputs take their reset values: ifu_rd_req=0, ifu_rd_addr=START_ADDR, instr_valid=0, instr=0, instr_pc=0, mem_op=0, iot_op=0, op7_op=0, done=0. The queue is empty and no reads are in flight.
REQ-032 Reset asserted mid-operation overrides pc_load, pops and pushes in the same cycle, and discards in-flight data.

Configuration
REQ-033 Macro IFD_HLT_STOP_EN selects HLT handling.
- Defined: the cycle an HLT word (7402 octal) is pushed, fetching stops. When that HLT is popped, the FSM enters DONE with done=1 and instr_valid=0 from the next cycle.
- Undefined: HLT is an ordinary instruction, done is tied to 0, and DONE is unreachable.

Verification
REQ-034 Release reset with memory returning 1234 octal -> ifu_rd_req=1 at START_ADDR in cycle 1, instr_valid=1 in cycle 3 with instr_pc=0200 and mem_op=000010.
REQ-035 DEPTH=4, stall held high -> exactly 4 reads at 0200..0203, then ifu_rd_req=0. Release stall -> 4 pops in order and fetch resumes at 0204.
REQ-036 pc_load with pc_value=0500 while 3 entries are queued and 1 read is in flight -> queue empty next cycle, in-flight word dropped, next request at 0500.
REQ-037 pc_value=7776 -> reads at 7776, 7777, 0000.
REQ-038 With IFD_HLT_STOP_EN defined, memory holds 7402 at 0201 -> no fetch beyond 0201; after HLT pops, done=1 and instr_valid=0 until reset. Without the macro -> 7402 pops with op7_op=1 and fetch continues at 0202.
REQ-039 Assert reset=1 for 1 cycle mid-fetch with a full queue -> all outputs at reset values the next cycle, then restart at START_ADDR.
